// File: rtl/irq_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// irq_controller: edge-captured, maskable, fixed-priority IRQ front end for CP0
// Rev 1.0
// ---------------------------------------------------------------------------
module irq_controller #(
  parameter int N_SRC = 8,
  parameter int ID_W  = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             irq_taken,
  input  logic             eret,
  output logic             irq_req,
  output logic             cause_valid,
  output logic [ID_W-1:0]  cause_id,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] mask,
  output logic [CNT_W-1:0] irq_count
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [N_SRC-1:0] prev_src;
  logic [N_SRC-1:0] pending_r;
  logic [N_SRC-1:0] mask_r;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] clr_vec;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  cause_id_r;
  logic [CNT_W-1:0] count_r;
  logic             take;

  always_comb begin
    eligible = pending_r & mask_r;
    rise     = irq_src & ~prev_src;
  end

  // Scan high to low so the lowest eligible index is the last one written.
  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = ID_W'(i);
      end
    end
  end

  always_comb begin
    take    = (state == S_REQ) && irq_taken;
    clr_vec = take ? (N_SRC'(1) << cause_id_r) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (|eligible) begin
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        // Acceptance beats a concurrent withdraw by mask.
        if (irq_taken) begin
          state_next = S_SERVICE;
        end else if (!mask_r[cause_id_r]) begin
          state_next = S_IDLE;
        end
      end
      S_SERVICE: begin
        if (eret) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    irq_req     = (state == S_REQ);
    cause_valid = (state == S_SERVICE);
  end

  // A fresh edge in the same cycle as the clear keeps the bit pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_src   <= '0;
      pending_r  <= '0;
      mask_r     <= '0;
      cause_id_r <= '0;
      count_r    <= '0;
    end else begin
      prev_src  <= irq_src;
      pending_r <= (pending_r & ~clr_vec) | rise;
      if (mask_we) begin
        mask_r <= mask_wdata;
      end
      if ((state == S_IDLE) && (|eligible)) begin
        cause_id_r <= winner;
      end
      if (take) begin
        count_r <= count_r + CNT_W'(1);
      end
    end
  end

  assign cause_id  = cause_id_r;
  assign pending   = pending_r;
  assign mask      = mask_r;
  assign irq_count = count_r;

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_irq_controller: vector table + scoreboard bench for irq_controller
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_irq_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  src = '0, mwd = '0;
  logic        mwe = 1'b0, tk = 1'b0, er = 1'b0;
  logic        req, val;
  logic [2:0]  id;
  logic [7:0]  pend, msk;
  logic [15:0] cnt;

  irq_controller #(.N_SRC(8), .ID_W(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .irq_src(src), .mask_we(mwe), .mask_wdata(mwd),
    .irq_taken(tk), .eret(er), .irq_req(req), .cause_valid(val),
    .cause_id(id), .pending(pend), .mask(msk), .irq_count(cnt)
  );

  // Small instance: two sources and a 2-bit counter to reach the wrap quickly.
  logic [1:0] src2 = '0, mwd2 = '0;
  logic       mwe2 = 1'b0, tk2 = 1'b0, er2 = 1'b0;
  logic       req2, val2;
  logic [0:0] id2;
  logic [1:0] pend2, msk2, cnt2;

  irq_controller #(.N_SRC(2), .ID_W(1), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .irq_src(src2), .mask_we(mwe2), .mask_wdata(mwd2),
    .irq_taken(tk2), .eret(er2), .irq_req(req2), .cause_valid(val2),
    .cause_id(id2), .pending(pend2), .mask(msk2), .irq_count(cnt2)
  );

  typedef struct {
    logic [7:0]  src;
    logic        mwe;
    logic [7:0]  mwd;
    logic        tk;
    logic        er;
    logic        req;
    logic        val;
    logic [2:0]  id;
    logic [7:0]  pend;
    logic [7:0]  mask;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(input logic [7:0] s, input logic we, input logic [7:0] wd,
                              input logic t, input logic e, input logic rq, input logic v,
                              input logic [2:0] i, input logic [7:0] p, input logic [7:0] m,
                              input logic [15:0] c);
    vec_t r;
    r.src = s; r.mwe = we; r.mwd = wd; r.tk = t; r.er = e;
    r.req = rq; r.val = v; r.id = i; r.pend = p; r.mask = m; r.cnt = c;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input vec_t v, input int idx);
    vec_t e;
    src = v.src; mwe = v.mwe; mwd = v.mwd; tk = v.tk; er = v.er;
    exp_q.push_back(v);
    tick();
    e = exp_q.pop_front();
    chk($sformatf("v%0d.irq_req", idx), 32'(req), 32'(e.req));
    chk($sformatf("v%0d.cause_valid", idx), 32'(val), 32'(e.val));
    if (e.req || e.val) chk($sformatf("v%0d.cause_id", idx), 32'(id), 32'(e.id));
    chk($sformatf("v%0d.pending", idx), 32'(pend), 32'(e.pend));
    chk($sformatf("v%0d.mask", idx), 32'(msk), 32'(e.mask));
    chk($sformatf("v%0d.irq_count", idx), 32'(cnt), 32'(e.cnt));
  endtask

  initial begin
    //               src   we wdata tk er  req val id pend   mask   cnt
    // single source 5
    tbl.push_back(mk(8'h00, 1, 8'hFF, 0, 0, 0, 0, 0, 8'h00, 8'hFF, 16'd0));
    tbl.push_back(mk(8'h20, 0, 8'h00, 0, 0, 0, 0, 0, 8'h20, 8'hFF, 16'd0));
    tbl.push_back(mk(8'h20, 0, 8'h00, 0, 0, 1, 0, 5, 8'h20, 8'hFF, 16'd0));
    tbl.push_back(mk(8'h20, 0, 8'h00, 1, 0, 0, 1, 5, 8'h00, 8'hFF, 16'd1));
    tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 0, 1, 5, 8'h00, 8'hFF, 16'd1));
    tbl.push_back(mk(8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 8'hFF, 16'd1));
    // sources 6 and 2 together: 2 first, then 6 right after eret
    tbl.push_back(mk(8'h44, 0, 8'h00, 0, 0, 0, 0, 0, 8'h44, 8'hFF, 16'd1));
    tbl.push_back(mk(8'h44, 0, 8'h00, 0, 0, 1, 0, 2, 8'h44, 8'hFF, 16'd1));
    tbl.push_back(mk(8'h00, 0, 8'h00, 1, 0, 0, 1, 2, 8'h40, 8'hFF, 16'd2));
    tbl.push_back(mk(8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 8'h40, 8'hFF, 16'd2));
    tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 1, 0, 6, 8'h40, 8'hFF, 16'd2));
    tbl.push_back(mk(8'h00, 0, 8'h00, 1, 0, 0, 1, 6, 8'h00, 8'hFF, 16'd3));
    tbl.push_back(mk(8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 8'hFF, 16'd3));
    // masked source 3 pends, request follows mask write by two cycles
    tbl.push_back(mk(8'h00, 1, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00, 16'd3));
    tbl.push_back(mk(8'h08, 0, 8'h00, 0, 0, 0, 0, 0, 8'h08, 8'h00, 16'd3));
    tbl.push_back(mk(8'h08, 0, 8'h00, 0, 0, 0, 0, 0, 8'h08, 8'h00, 16'd3));
    tbl.push_back(mk(8'h08, 1, 8'h08, 0, 0, 0, 0, 0, 8'h08, 8'h08, 16'd3));
    tbl.push_back(mk(8'h08, 0, 8'h00, 0, 0, 1, 0, 3, 8'h08, 8'h08, 16'd3));
    tbl.push_back(mk(8'h08, 0, 8'h00, 1, 0, 0, 1, 3, 8'h00, 8'h08, 16'd4));
    tbl.push_back(mk(8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 8'h08, 16'd4));
    // source 4 withdrawn by mask while waiting, then restored
    tbl.push_back(mk(8'h00, 1, 8'hFF, 0, 0, 0, 0, 0, 8'h00, 8'hFF, 16'd4));
    tbl.push_back(mk(8'h10, 0, 8'h00, 0, 0, 0, 0, 0, 8'h10, 8'hFF, 16'd4));
    tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 1, 0, 4, 8'h10, 8'hFF, 16'd4));
    tbl.push_back(mk(8'h00, 1, 8'hEF, 0, 0, 1, 0, 4, 8'h10, 8'hEF, 16'd4));
    tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 8'h10, 8'hEF, 16'd4));
    tbl.push_back(mk(8'h00, 1, 8'hFF, 0, 0, 0, 0, 0, 8'h10, 8'hFF, 16'd4));
    tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 1, 0, 4, 8'h10, 8'hFF, 16'd4));
    // taken while the source is already masked: taken wins
    tbl.push_back(mk(8'h00, 1, 8'hEF, 0, 0, 1, 0, 4, 8'h10, 8'hEF, 16'd4));
    tbl.push_back(mk(8'h00, 0, 8'h00, 1, 0, 0, 1, 4, 8'h00, 8'hEF, 16'd5));
    tbl.push_back(mk(8'h00, 1, 8'hFF, 0, 1, 0, 0, 0, 8'h00, 8'hFF, 16'd5));
    // source 1 held high, re-edge during service, ignored taken in service
    tbl.push_back(mk(8'h02, 0, 8'h00, 0, 0, 0, 0, 0, 8'h02, 8'hFF, 16'd5));
    tbl.push_back(mk(8'h02, 0, 8'h00, 0, 0, 1, 0, 1, 8'h02, 8'hFF, 16'd5));
    tbl.push_back(mk(8'h02, 0, 8'h00, 1, 0, 0, 1, 1, 8'h00, 8'hFF, 16'd6));
    tbl.push_back(mk(8'h02, 0, 8'h00, 0, 0, 0, 1, 1, 8'h00, 8'hFF, 16'd6));
    tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 0, 1, 1, 8'h00, 8'hFF, 16'd6));
    tbl.push_back(mk(8'h02, 0, 8'h00, 0, 0, 0, 1, 1, 8'h02, 8'hFF, 16'd6));
    tbl.push_back(mk(8'h02, 0, 8'h00, 1, 0, 0, 1, 1, 8'h02, 8'hFF, 16'd6));
    tbl.push_back(mk(8'h02, 0, 8'h00, 0, 1, 0, 0, 0, 8'h02, 8'hFF, 16'd6));
    tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 1, 0, 1, 8'h02, 8'hFF, 16'd6));
    // new edge in the same cycle as the clear: bit stays pending
    tbl.push_back(mk(8'h02, 0, 8'h00, 1, 0, 0, 1, 1, 8'h02, 8'hFF, 16'd7));
    tbl.push_back(mk(8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 8'h02, 8'hFF, 16'd7));
    tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 1, 0, 1, 8'h02, 8'hFF, 16'd7));
    tbl.push_back(mk(8'h00, 0, 8'h00, 1, 0, 0, 1, 1, 8'h00, 8'hFF, 16'd8));

    rst = 1'b1;
    tick();
    tick();
    chk("reset.irq_req", 32'(req), 32'd0);
    chk("reset.cause_valid", 32'(val), 32'd0);
    chk("reset.cause_id", 32'(id), 32'd0);
    chk("reset.pending", 32'(pend), 32'd0);
    chk("reset.mask", 32'(msk), 32'd0);
    chk("reset.irq_count", 32'(cnt), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], i);
    end

    // Reset while in SERVICE, with a line held high across reset release.
    src = 8'h01; mwe = 1'b0; tk = 1'b0; er = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst.cause_valid", 32'(val), 32'd0);
    chk("midrst.irq_req", 32'(req), 32'd0);
    chk("midrst.pending", 32'(pend), 32'd0);
    chk("midrst.mask", 32'(msk), 32'd0);
    chk("midrst.irq_count", 32'(cnt), 32'd0);
    rst = 1'b0;
    tick();
    chk("relhigh.pending", 32'(pend), 32'h01);
    chk("relhigh.irq_req", 32'(req), 32'd0);
    src = 8'h00;
    tick();
    chk("relhigh.masked_req", 32'(req), 32'd0);

    // Counter wrap on the small instance.
    mwe2 = 1'b1; mwd2 = 2'b11;
    tick();
    mwe2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      src2 = k[0] ? 2'b10 : 2'b01;
      tick();
      src2 = 2'b00;
      tick();
      chk($sformatf("wrap%0d.irq_req", k), 32'(req2), 32'd1);
      chk($sformatf("wrap%0d.cause_id", k), 32'(id2), 32'(k[0]));
      tk2 = 1'b1;
      tick();
      tk2 = 1'b0;
      chk($sformatf("wrap%0d.cause_valid", k), 32'(val2), 32'd1);
      chk($sformatf("wrap%0d.irq_count", k), 32'(cnt2), 32'((k + 1) % 4));
      er2 = 1'b1;
      tick();
      er2 = 1'b0;
      chk($sformatf("wrap%0d.idle", k), 32'(val2), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
